// File: rtl/bridge_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : bridge_timer_if
// Description : Peripheral-bus bundle between the bridge and bridge_timer.
//               master modport = bridge side, slave modport = timer side.
//   addr [1:0]  word select (bus address bits [3:2])
//   we          write strobe, one cycle per write
//   wd   [31:0] write data
//   be   [3:0]  byte enables, be[i] covers wd[8i+7:8i]
//   rd   [31:0] read data, combinational from addr
//   irq         interrupt request toward the bridge
// Revision    : 1.0 - initial release
// ============================================================================
interface bridge_timer_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [3:0]  be;
  logic [31:0] rd;
  logic        irq;

  modport master (
    output addr, we, wd, be,
    input  rd, irq
  );

  modport slave (
    input  addr, we, wd, be,
    output rd, irq
  );
endinterface
`default_nettype wire

// File: rtl/bridge_timer.sv
`default_nettype none
// ============================================================================
// Module      : bridge_timer
// Description : Programmable 32-bit down-counting timer on the bridge's
//               peripheral bus. One-shot mode holds its interrupt until the
//               next CTRL write; auto-reload mode emits a one-cycle pulse
//               every PRESET+2 cycles.
//   clk        system clock
//   rst        synchronous, active-high reset
//   bus        bridge_timer_if.slave (addr, we, wd, be in; rd, irq out)
//   Register map: 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET, 2 COUNT (RO), 3 zero
// Revision    : 1.0 - initial release
// ============================================================================
module bridge_timer #(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000,
  parameter logic [3:0]  CTRL_RST   = 4'b0000
) (
  input  wire logic      clk,
  input  wire logic      rst,
  bridge_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] c_addr_ctrl   = 2'd0;
  localparam logic [1:0] c_addr_preset = 2'd1;
  localparam logic [1:0] c_addr_count  = 2'd2;
  localparam logic [1:0] c_mode_auto   = 2'b01;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] w_preset_nxt;
  logic [31:0] r_count;
  logic [31:0] w_count_nxt;
  logic        r_pend;
  logic        r_auto_pulse;
  logic        w_int_fire;
  logic        w_clr_en;
  logic        w_ctrl_wr;
  logic        w_preset_wr;
  logic        w_en;
  logic        w_auto;
  logic [31:0] w_rd;

  assign w_ctrl_wr   = bus.we && (bus.addr == c_addr_ctrl) && bus.be[0];
  assign w_preset_wr = bus.we && (bus.addr == c_addr_preset);
  assign w_en        = r_ctrl[0];
  // MODE 1x falls back to one-shot; only 01 reloads.
  assign w_auto      = (r_ctrl[2:1] == c_mode_auto);

  // --------------------------------------------------------------------------
  // PRESET byte lanes
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < 4; i++) begin : g_preset_byte
    assign w_preset_nxt[8*i +: 8] = (w_preset_wr && bus.be[i]) ?
                                    bus.wd[8*i +: 8] : r_preset[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_preset <= PRESET_RST;
    end else begin
      r_preset <= w_preset_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Counter FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_int_fire  = 1'b0;
    w_clr_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_en) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!w_en) begin
          // Pause: COUNT holds; re-enabling goes through LOAD again.
          w_state_nxt = ST_IDLE;
        end else if (r_count > 32'd1) begin
          w_count_nxt = r_count - 32'd1;
        end else begin
          // COUNT of 0 or 1 both expire here, so PRESET=0 acts like 1.
          w_count_nxt = 32'd0;
          w_state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        w_int_fire = 1'b1;
        if (w_auto) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_clr_en    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // CTRL register: a bus write beats the one-shot EN clear from INT.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= CTRL_RST;
    end else if (w_ctrl_wr) begin
      r_ctrl <= bus.wd[3:0];
    end else if (w_clr_en) begin
      r_ctrl[0] <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Pending flag. INT's set has priority over every clear source; an
  // auto-reload set is cleared on the very next edge to form a one-cycle
  // pulse, a one-shot set waits for a CTRL write.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend       <= 1'b0;
      r_auto_pulse <= 1'b0;
    end else begin
      r_auto_pulse <= w_int_fire && w_auto;
      if (w_int_fire) begin
        r_pend <= 1'b1;
      end else if (r_auto_pulse) begin
        r_pend <= 1'b0;
      end else if (w_ctrl_wr) begin
        r_pend <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read mux and interrupt
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd = 32'd0;
    case (bus.addr)
      c_addr_ctrl:   w_rd = {28'd0, r_ctrl};
      c_addr_preset: w_rd = r_preset;
      c_addr_count:  w_rd = r_count;
      default:       w_rd = 32'd0;
    endcase
  end

  assign bus.rd  = w_rd;
  // Built from the registered PEND so the bus has no combinational path to irq.
  assign bus.irq = r_pend & r_ctrl[3];

endmodule
`default_nettype wire

// File: tb/tb_bridge_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bridge_timer
// Description : Self-checking bench for bridge_timer. Directed scenarios plus
//               randomized trials compared against an arithmetic timeline
//               model of the timer (count and irq as functions of elapsed
//               cycles since the enabling write).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bridge_timer;

  localparam logic [31:0] PRESET_RST = 32'h0000_1234;
  localparam logic [3:0]  CTRL_RST   = 4'b0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  bridge_timer_if bus ();

  bridge_timer #(
    .PRESET_RST (PRESET_RST),
    .CTRL_RST   (CTRL_RST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference timeline. t = number of edges elapsed since the edge that
  // captured the enabling CTRL write (timer freshly reset before that).
  // --------------------------------------------------------------------------
  function automatic logic [31:0] model_count(int t, int n, bit auto_mode);
    int ne;
    int p;
    ne = (n < 1) ? 1 : n;
    if (t < 2) return 32'd0;
    p = t - 2;
    if (auto_mode) p = p % (ne + 2);
    if (p == 0) return n;
    if (p < ne) return ne - p;
    return 32'd0;
  endfunction

  function automatic bit model_irq(int t, int n, bit auto_mode, bit im);
    int ne;
    ne = (n < 1) ? 1 : n;
    if (!im || t < ne + 3) return 1'b0;
    if (!auto_mode) return 1'b1;
    return ((t - ne - 3) % (ne + 2)) == 0;
  endfunction

  // --------------------------------------------------------------------------
  // Bus helpers (inputs change 1 ns after the rising edge)
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d,
                           input logic [3:0] b);
    bus.addr = a;
    bus.wd   = d;
    bus.be   = b;
    bus.we   = 1'b1;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    bus.be = 4'b0000;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rd;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] d;
    apply_reset();
    bus_read(2'd0, d);
    n_checks++;
    if (d !== {28'd0, CTRL_RST}) begin
      n_errors++; $display("FAIL reset_ctrl got %h exp %h", d, {28'd0, CTRL_RST});
    end
    bus_read(2'd1, d);
    n_checks++;
    if (d !== PRESET_RST) begin
      n_errors++; $display("FAIL reset_preset got %h exp %h", d, PRESET_RST);
    end
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_errors++; $display("FAIL reset_count got %h exp 0", d);
    end
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_errors++; $display("FAIL reset_irq got %b exp 0", bus.irq);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    apply_reset();
    bus_write(2'd1, 32'd5, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);      // e0
    tick();
    tick();                            // after e2
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'd5) begin
      n_errors++; $display("FAIL oneshot_load got %0d exp 5", d);
    end
    for (int t = 3; t <= 8; t++) begin
      tick();
      n_checks++;
      if (bus.irq !== (t == 8)) begin
        n_errors++; $display("FAIL oneshot_irq t=%0d got %b exp %b", t, bus.irq, (t == 8));
      end
    end
    bus_read(2'd0, d);
    n_checks++;
    if (d !== 32'h8) begin
      n_errors++; $display("FAIL oneshot_en_clear got %h exp 8", d);
    end
    tick();
    n_checks++;
    if (bus.irq !== 1'b1) begin
      n_errors++; $display("FAIL oneshot_irq_hold got %b exp 1", bus.irq);
    end
    bus_write(2'd0, 32'h8, 4'h1);
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_errors++; $display("FAIL oneshot_irq_ack got %b exp 0", bus.irq);
    end
  endtask

  task automatic test_autoreload();
    int pulses = 0;
    apply_reset();
    bus_write(2'd1, 32'd3, 4'hF);
    bus_write(2'd0, 32'hB, 4'hF);      // e0
    for (int t = 1; t <= 55; t++) begin
      tick();
      n_checks++;
      if (bus.irq !== model_irq(t, 3, 1'b1, 1'b1)) begin
        n_errors++; $display("FAIL auto_irq t=%0d got %b exp %b", t, bus.irq, model_irq(t, 3, 1'b1, 1'b1));
      end
      if (t >= 6 && bus.irq === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 10) begin
      n_errors++; $display("FAIL auto_pulse_count got %0d exp 10", pulses);
    end
  endtask

  task automatic test_pause();
    logic [31:0] d;
    apply_reset();
    bus_write(2'd1, 32'd20, 4'hF);
    bus_write(2'd0, 32'h1, 4'hF);      // e0
    for (int t = 1; t <= 14; t++) tick();
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'd8) begin
      n_errors++; $display("FAIL pause_pre got %0d exp 8", d);
    end
    bus_write(2'd0, 32'h0, 4'h1);      // e15: count drops to 7, EN cleared
    for (int t = 0; t < 10; t++) begin
      tick();
      bus_read(2'd2, d);
      n_checks++;
      if (d !== 32'd7) begin
        n_errors++; $display("FAIL pause_hold cyc=%0d got %0d exp 7", t, d);
      end
    end
    bus_write(2'd0, 32'h1, 4'h1);      // f0
    tick();
    tick();                            // after f2
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'd20) begin
      n_errors++; $display("FAIL pause_reload got %0d exp 20", d);
    end
  endtask

  task automatic test_byte_enables();
    logic [31:0] d;
    apply_reset();
    bus_write(2'd1, 32'h0, 4'hF);
    bus_write(2'd1, 32'hAABB_CCDD, 4'b0101);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h00BB_00DD) begin
      n_errors++; $display("FAIL be_preset got %h exp 00bb00dd", d);
    end
    bus_write(2'd2, 32'hDEAD_BEEF, 4'hF);
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_errors++; $display("FAIL be_count_ro got %h exp 0", d);
    end
    bus_write(2'd0, 32'hF, 4'b1110);
    bus_read(2'd0, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_errors++; $display("FAIL be_ctrl_b0 got %h exp 0", d);
    end
    bus_write(2'd3, 32'hFFFF_FFFF, 4'hF);
    bus_read(2'd3, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_errors++; $display("FAIL be_addr3 got %h exp 0", d);
    end
  endtask

  task automatic test_mask();
    logic [31:0] d;
    bit seen = 1'b0;
    apply_reset();
    bus_write(2'd1, 32'd2, 4'hF);
    bus_write(2'd0, 32'h1, 4'hF);      // IM=0 one-shot
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (bus.irq !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_errors++; $display("FAIL mask_irq got 1 exp 0");
    end
    bus_read(2'd0, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_errors++; $display("FAIL mask_expired_ctrl got %h exp 0", d);
    end
    bus_write(2'd0, 32'h8, 4'h1);      // IM=1, clears PEND
    for (int t = 0; t < 4; t++) begin
      n_checks++;
      if (bus.irq !== 1'b0) begin
        n_errors++; $display("FAIL mask_unmask cyc=%0d got %b exp 0", t, bus.irq);
      end
      tick();
    end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] d;
    bit bad_irq = 1'b0;
    bit bad_cnt = 1'b0;
    apply_reset();
    bus_write(2'd1, 32'd200, 4'hF);
    bus_write(2'd0, 32'hB, 4'hF);      // e0
    for (int t = 1; t <= 102; t++) tick();
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'd100) begin
      n_errors++; $display("FAIL midrst_pre got %0d exp 100", d);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_errors++; $display("FAIL midrst_count got %0d exp 0", d);
    end
    bus_read(2'd1, d);
    n_checks++;
    if (d !== PRESET_RST) begin
      n_errors++; $display("FAIL midrst_preset got %h exp %h", d, PRESET_RST);
    end
    for (int t = 0; t < 300; t++) begin
      tick();
      bus_read(2'd2, d);
      if (bus.irq !== 1'b0) bad_irq = 1'b1;
      if (d !== 32'd0) bad_cnt = 1'b1;
    end
    n_checks++;
    if (bad_irq || bad_cnt) begin
      n_errors++; $display("FAIL midrst_idle irq_seen=%b count_moved=%b exp 0/0", bad_irq, bad_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int k = 0; k < 8; k++) begin
      int         n;
      int         ne;
      logic [1:0] mode;
      bit         im;
      bit         auto_mode;
      n         = int'($urandom_range(0, 12));
      mode      = 2'($urandom_range(0, 3));
      im        = 1'($urandom_range(0, 1));
      auto_mode = (mode == 2'b01);
      ne        = (n < 1) ? 1 : n;
      apply_reset();
      bus_write(2'd1, n, 4'hF);
      bus_write(2'd0, {28'd0, im, mode, 1'b1}, 4'hF);
      for (int t = 1; t <= 3 * (ne + 2) + 4; t++) begin
        tick();
        bus_read(2'd2, d);
        n_checks++;
        if (d !== model_count(t, n, auto_mode)) begin
          n_errors++; $display("FAIL rand_count trial=%0d n=%0d mode=%0d t=%0d got %0d exp %0d", k, n, mode, t, d, model_count(t, n, auto_mode));
        end
        n_checks++;
        if (bus.irq !== model_irq(t, n, auto_mode, im)) begin
          n_errors++; $display("FAIL rand_irq trial=%0d n=%0d mode=%0d im=%0d t=%0d got %b exp %b", k, n, mode, im, t, bus.irq, model_irq(t, n, auto_mode, im));
        end
      end
      bus_read(2'd0, d);
      n_checks++;
      if (d[0] !== auto_mode) begin
        n_errors++; $display("FAIL rand_en trial=%0d mode=%0d got %b exp %b", k, mode, d[0], auto_mode);
      end
    end
  endtask

  initial begin
    bus.addr = 2'd0;
    bus.we   = 1'b0;
    bus.wd   = 32'd0;
    bus.be   = 4'b0000;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_pause();
    test_byte_enables();
    test_mask();
    test_reset_midcount();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
